// File: rtl/uart_hex_frame_rx.sv
// ASCII-hex frame receiver: decodes ":<hex pairs>;" frames from a UART byte
// stream into WORD_BYTES-wide words. It optionally verifies a trailing checksum
// byte and enforces a word-count limit. Each frame close queues a one-byte
// ACK/NAK reply for the transmitter over a valid/ready handshake.
module uart_hex_frame_rx #(
   parameter int         WORD_BYTES = 2,
   parameter int         MAX_WORDS  = 64,
   parameter int         CHECKSUM   = 1,
   parameter logic [7:0] ACK_CHAR   = 8'h4B,
   parameter logic [7:0] NAK_CHAR   = 8'h45
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [7:0]              i_rx_data,
   input  logic                    i_rx_valid,
   output logic [8*WORD_BYTES-1:0] o_word,
   output logic                    o_word_valid,
   output logic                    o_word_start,
   output logic                    o_frame_end,
   output logic                    o_frame_error,
   output logic [2:0]              o_err_code,
   output logic [7:0]              o_tx_byte,
   output logic                    o_tx_valid,
   input  logic                    i_tx_ready
);

   localparam int WW  = 8 * WORD_BYTES;
   localparam int BCW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam int WCW = $clog2(MAX_WORDS + 1);
   localparam logic [BCW-1:0] LAST_BYTE = BCW'(WORD_BYTES - 1);
   localparam logic [WCW-1:0] MAX_CNT   = WCW'(MAX_WORDS);

   localparam logic [2:0] ERR_OK      = 3'd0;
   localparam logic [2:0] ERR_BADCHAR = 3'd1;
   localparam logic [2:0] ERR_RESYNC  = 3'd2;
   localparam logic [2:0] ERR_LENGTH  = 3'd3;
   localparam logic [2:0] ERR_CKSUM   = 3'd4;

   localparam logic [7:0] CH_COLON = 8'h3A;
   localparam logic [7:0] CH_SEMI  = 8'h3B;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HI   = 2'd1,
      ST_LO   = 2'd2
   } state_t;

   // Returns {is_hex, nibble}; only 0-9, a-f, A-F count as hex.
   function automatic logic [4:0] hex_decode(input logic [7:0] c);
      logic [4:0] r;
      if ((c >= 8'h30) && (c <= 8'h39)) begin
         r = {1'b1, 4'(c - 8'h30)};
      end else if ((c >= 8'h61) && (c <= 8'h66)) begin
         r = {1'b1, 4'(c - 8'h57)};
      end else if ((c >= 8'h41) && (c <= 8'h46)) begin
         r = {1'b1, 4'(c - 8'h37)};
      end else begin
         r = 5'd0;
      end
      return r;
   endfunction

   state_t           state_q, state_d;
   logic [3:0]       nib_q, nib_d;
   logic [7:0]       hold_q, hold_d;
   logic             hold_valid_q, hold_valid_d;
   logic [7:0]       sum_q, sum_d;
   logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
   logic [WCW-1:0]   word_cnt_q, word_cnt_d;
   logic [WW-1:0]    acc_q, acc_d;
   logic [WW-1:0]    word_q, word_d;
   logic             word_valid_q, word_valid_d;
   logic             word_start_q, word_start_d;
   logic             frame_end_q, frame_end_d;
   logic             frame_error_q, frame_error_d;
   logic [2:0]       err_code_q, err_code_d;
   logic [7:0]       tx_byte_q, tx_byte_d;
   logic             tx_valid_q, tx_valid_d;

   logic [4:0]       hex_s;
   logic [7:0]       byte_full_s;
   logic             byte_done_s;
   logic             close_s;
   logic [2:0]       close_code_s;
   logic             new_frame_s;
   logic             asm_en_s;
   logic [7:0]       asm_byte_s;
   logic [WW-1:0]    acc_shift_s;

   // Next-state logic: frame FSM, byte/word assembly, error coding, reply queue.
   always_comb begin
      state_d       = state_q;
      nib_d         = nib_q;
      hold_d        = hold_q;
      hold_valid_d  = hold_valid_q;
      sum_d         = sum_q;
      byte_cnt_d    = byte_cnt_q;
      word_cnt_d    = word_cnt_q;
      acc_d         = acc_q;
      word_d        = word_q;
      word_valid_d  = 1'b0;
      word_start_d  = 1'b0;
      frame_end_d   = 1'b0;
      frame_error_d = 1'b0;
      err_code_d    = ERR_OK;
      tx_byte_d     = tx_byte_q;
      tx_valid_d    = tx_valid_q;
      byte_done_s   = 1'b0;
      close_s       = 1'b0;
      close_code_s  = ERR_OK;
      new_frame_s   = 1'b0;
      asm_en_s      = 1'b0;
      asm_byte_s    = 8'h00;
      hex_s         = hex_decode(i_rx_data);
      byte_full_s   = {nib_q, hex_s[3:0]};

      if (i_rx_valid) begin
         case (state_q)
            ST_IDLE: begin
               if (i_rx_data == CH_COLON) begin
                  new_frame_s = 1'b1;
                  state_d     = ST_HI;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_HI: begin
               if (hex_s[4]) begin
                  nib_d   = hex_s[3:0];
                  state_d = ST_LO;
               end else if (i_rx_data == CH_SEMI) begin
                  close_s = 1'b1;
                  state_d = ST_IDLE;
                  // Partial word or a missing checksum byte outranks a bad sum.
                  if ((byte_cnt_q != '0) || ((CHECKSUM != 0) && !hold_valid_q)) begin
                     close_code_s = ERR_LENGTH;
                  end else if ((CHECKSUM != 0) && (sum_q != 8'h00)) begin
                     close_code_s = ERR_CKSUM;
                  end else begin
                     close_code_s = ERR_OK;
                  end
               end else if (i_rx_data == CH_COLON) begin
                  close_s      = 1'b1;
                  close_code_s = ERR_RESYNC;
                  new_frame_s  = 1'b1;
                  state_d      = ST_HI;
               end else begin
                  close_s      = 1'b1;
                  close_code_s = ERR_BADCHAR;
                  state_d      = ST_IDLE;
               end
            end
            ST_LO: begin
               if (hex_s[4]) begin
                  byte_done_s = 1'b1;
                  state_d     = ST_HI;
               end else if (i_rx_data == CH_COLON) begin
                  close_s      = 1'b1;
                  close_code_s = ERR_RESYNC;
                  new_frame_s  = 1'b1;
                  state_d      = ST_HI;
               end else begin
                  close_s      = 1'b1;
                  close_code_s = ERR_BADCHAR;
                  state_d      = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end else begin
         state_d = state_q;
      end

      // A completed byte joins the sum; with a checksum it passes through the
      // lookahead register so the final byte before ';' never becomes data.
      if (byte_done_s) begin
         sum_d = sum_q + byte_full_s;
         if (CHECKSUM != 0) begin
            asm_en_s     = hold_valid_q;
            asm_byte_s   = hold_q;
            hold_d       = byte_full_s;
            hold_valid_d = 1'b1;
         end else begin
            asm_en_s   = 1'b1;
            asm_byte_s = byte_full_s;
         end
      end else begin
         sum_d = sum_q;
      end

      acc_shift_s = (acc_q << 8) | WW'(asm_byte_s);

      // Word assembler: first byte ends up in the MSBs.
      if (asm_en_s) begin
         if (byte_cnt_q == LAST_BYTE) begin
            if (word_cnt_q == MAX_CNT) begin
               close_s      = 1'b1;
               close_code_s = ERR_LENGTH;
               state_d      = ST_IDLE;
            end else begin
               word_d       = acc_shift_s;
               word_valid_d = 1'b1;
               word_start_d = (word_cnt_q == '0);
               word_cnt_d   = word_cnt_q + WCW'(1);
            end
            byte_cnt_d = '0;
            acc_d      = '0;
         end else begin
            acc_d      = acc_shift_s;
            byte_cnt_d = byte_cnt_q + BCW'(1);
         end
      end else begin
         acc_d = acc_q;
      end

      if (new_frame_s) begin
         byte_cnt_d   = '0;
         word_cnt_d   = '0;
         sum_d        = 8'h00;
         hold_valid_d = 1'b0;
         acc_d        = '0;
      end else begin
         hold_valid_d = hold_valid_d;
      end

      // Reply queue: accept clears, a fresh close (even the same cycle) wins.
      if (tx_valid_q && i_tx_ready) begin
         tx_valid_d = 1'b0;
      end else begin
         tx_valid_d = tx_valid_q;
      end

      if (close_s) begin
         frame_end_d   = 1'b1;
         frame_error_d = (close_code_s != ERR_OK);
         err_code_d    = close_code_s;
         tx_byte_d     = (close_code_s == ERR_OK) ? ACK_CHAR : NAK_CHAR;
         tx_valid_d    = 1'b1;
      end else begin
         frame_end_d = 1'b0;
      end
   end

   // State and output registers; asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         nib_q         <= 4'h0;
         hold_q        <= 8'h00;
         hold_valid_q  <= 1'b0;
         sum_q         <= 8'h00;
         byte_cnt_q    <= '0;
         word_cnt_q    <= '0;
         acc_q         <= '0;
         word_q        <= '0;
         word_valid_q  <= 1'b0;
         word_start_q  <= 1'b0;
         frame_end_q   <= 1'b0;
         frame_error_q <= 1'b0;
         err_code_q    <= 3'd0;
         tx_byte_q     <= 8'h00;
         tx_valid_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         nib_q         <= nib_d;
         hold_q        <= hold_d;
         hold_valid_q  <= hold_valid_d;
         sum_q         <= sum_d;
         byte_cnt_q    <= byte_cnt_d;
         word_cnt_q    <= word_cnt_d;
         acc_q         <= acc_d;
         word_q        <= word_d;
         word_valid_q  <= word_valid_d;
         word_start_q  <= word_start_d;
         frame_end_q   <= frame_end_d;
         frame_error_q <= frame_error_d;
         err_code_q    <= err_code_d;
         tx_byte_q     <= tx_byte_d;
         tx_valid_q    <= tx_valid_d;
      end
   end

   assign o_word        = word_q;
   assign o_word_valid  = word_valid_q;
   assign o_word_start  = word_start_q;
   assign o_frame_end   = frame_end_q;
   assign o_frame_error = frame_error_q;
   assign o_err_code    = err_code_q;
   assign o_tx_byte     = tx_byte_q;
   assign o_tx_valid    = tx_valid_q;

endmodule
